// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: config shadowing, frame sequencing and good-byte FIFO for the UART receiver; push -> rd_valid next cycle.
// Consumer backpressure via rd_ready; a full FIFO drops bytes (sticky overflow). UART_RX_CTRL_ERRCNT_EN enables error counters.

module uart_rx_ctrl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   push_vld,
    input  logic [WIDTH-1:0]       push_dat,
    output logic                   push_rdy,
    output logic                   pop_vld,
    input  logic                   pop_rdy,
    output logic [WIDTH-1:0]       pop_dat,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign full     = (cnt_q == (AW+1)'(DEPTH));
    assign pop_vld  = (cnt_q != '0);
    assign do_pop   = pop_vld & pop_rdy;
    assign push_rdy = ~full | do_pop;
    assign do_push  = push_vld & push_rdy;
    assign pop_dat  = pop_vld ? mem_q[rd_ptr_q] : '0;
    assign level    = cnt_q;

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

module uart_rx_ctrl #(
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 8,
    parameter int RST_PRESC = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   RX_IN,
    input  logic                   cfg_update,
    input  logic [5:0]             cfg_prescale,
    input  logic                   cfg_parity_en,
    input  logic                   cfg_parity_type,
    output logic                   cfg_pending,
    output logic                   cfg_reject,
    output logic [5:0]             uart_prescale,
    output logic                   uart_parity_en,
    output logic                   uart_parity_type,
    input  logic                   rx_data_valid,
    input  logic [7:0]             rx_p_data,
    input  logic                   rx_parity_error,
    input  logic                   rx_stop_error,
    output logic [7:0]             rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    input  logic                   err_clear,
    output logic [CNT_W-1:0]       parity_err_cnt,
    output logic [CNT_W-1:0]       stop_err_cnt
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FRAME,
        ST_WAIT_HI
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] rx_sync_q;
    logic       dv_prev_q, pe_prev_q, se_prev_q;
    logic [5:0] shd_presc_q, shd_presc_d;
    logic       shd_pen_q, shd_pen_d;
    logic       shd_ptype_q, shd_ptype_d;
    logic       cfg_pending_q, cfg_pending_d;
    logic       cfg_reject_q, cfg_reject_d;
    logic [5:0] presc_q, presc_d;
    logic       pen_q, pen_d;
    logic       ptype_q, ptype_d;
    logic [9:0] tmo_q, tmo_d;
    logic       overflow_q, overflow_d;

    logic       rx_s;
    logic       dv_edge, pe_edge, se_edge, err_edge;
    logic       cfg_legal;
    logic       push_req;
    logic       push_rdy;

    assign rx_s      = rx_sync_q[1];
    assign dv_edge   = rx_data_valid & ~dv_prev_q;
    assign pe_edge   = rx_parity_error & ~pe_prev_q;
    assign se_edge   = rx_stop_error & ~se_prev_q;
    assign err_edge  = pe_edge | se_edge;
    assign cfg_legal = (cfg_prescale == 6'd4) || (cfg_prescale == 6'd8) ||
                       (cfg_prescale == 6'd16) || (cfg_prescale == 6'd32);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            rx_sync_q     <= 2'b11;
            dv_prev_q     <= 1'b0;
            pe_prev_q     <= 1'b0;
            se_prev_q     <= 1'b0;
            shd_presc_q   <= 6'(RST_PRESC);
            shd_pen_q     <= 1'b0;
            shd_ptype_q   <= 1'b0;
            cfg_pending_q <= 1'b0;
            cfg_reject_q  <= 1'b0;
            presc_q       <= 6'(RST_PRESC);
            pen_q         <= 1'b0;
            ptype_q       <= 1'b0;
            tmo_q         <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_sync_q     <= {rx_sync_q[0], RX_IN};
            dv_prev_q     <= rx_data_valid;
            pe_prev_q     <= rx_parity_error;
            se_prev_q     <= rx_stop_error;
            shd_presc_q   <= shd_presc_d;
            shd_pen_q     <= shd_pen_d;
            shd_ptype_q   <= shd_ptype_d;
            cfg_pending_q <= cfg_pending_d;
            cfg_reject_q  <= cfg_reject_d;
            presc_q       <= presc_d;
            pen_q         <= pen_d;
            ptype_q       <= ptype_d;
            tmo_q         <= tmo_d;
            overflow_q    <= overflow_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        shd_presc_d   = shd_presc_q;
        shd_pen_d     = shd_pen_q;
        shd_ptype_d   = shd_ptype_q;
        cfg_pending_d = cfg_pending_q;
        cfg_reject_d  = 1'b0;
        presc_d       = presc_q;
        pen_d         = pen_q;
        ptype_d       = ptype_q;
        tmo_d         = tmo_q;
        push_req      = 1'b0;

        if (cfg_update) begin
            if (cfg_legal) begin
                shd_presc_d   = cfg_prescale;
                shd_pen_d     = cfg_parity_en;
                shd_ptype_d   = cfg_parity_type;
                cfg_pending_d = 1'b1;
            end else begin
                cfg_reject_d  = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                // Applying config takes priority so a new frame always starts on settled receiver settings.
                if (cfg_pending_q && !cfg_update) begin
                    presc_d       = shd_presc_q;
                    pen_d         = shd_pen_q;
                    ptype_d       = shd_ptype_q;
                    cfg_pending_d = 1'b0;
                end else if (!rx_s) begin
                    state_d = ST_FRAME;
                    tmo_d   = 10'(presc_q) * 10'd12;
                end
            end
            ST_FRAME: begin
                if (err_edge) begin
                    state_d = ST_WAIT_HI;
                end else if (dv_edge) begin
                    push_req = 1'b1;
                    state_d  = ST_WAIT_HI;
                end else if (tmo_q == '0) begin
                    state_d = ST_WAIT_HI;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            ST_WAIT_HI: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A drop on the clear cycle must survive the clear.
        overflow_d = (overflow_q & ~err_clear) | (push_req & ~push_rdy);
    end

    uart_rx_ctrl_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .push_vld (push_req),
        .push_dat (rx_p_data),
        .push_rdy (push_rdy),
        .pop_vld  (rd_valid),
        .pop_rdy  (rd_ready),
        .pop_dat  (rd_data),
        .level    (fifo_level)
    );

`ifdef UART_RX_CTRL_ERRCNT_EN
    logic [CNT_W-1:0] pe_cnt_q, se_cnt_q;
    logic             pe_inc, se_inc;

    assign pe_inc = (state_q == ST_FRAME) & pe_edge;
    assign se_inc = (state_q == ST_FRAME) & se_edge;

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                  input logic inc, input logic clr);
        if (clr) begin
            return inc ? CNT_W'(1) : '0;
        end else if (inc && (cur != '1)) begin
            return cur + 1'b1;
        end
        return cur;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pe_cnt_q <= '0;
            se_cnt_q <= '0;
        end else begin
            pe_cnt_q <= cnt_next(pe_cnt_q, pe_inc, err_clear);
            se_cnt_q <= cnt_next(se_cnt_q, se_inc, err_clear);
        end
    end

    assign parity_err_cnt = pe_cnt_q;
    assign stop_err_cnt   = se_cnt_q;
`else
    assign parity_err_cnt = '0;
    assign stop_err_cnt   = '0;
`endif

    assign cfg_pending      = cfg_pending_q;
    assign cfg_reject       = cfg_reject_q;
    assign uart_prescale    = presc_q;
    assign uart_parity_en   = pen_q;
    assign uart_parity_type = ptype_q;
    assign overflow         = overflow_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: receiver flags and the serial line are driven directly.
module tb_uart_rx_ctrl;
    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       cfg_update;
    logic [5:0] cfg_prescale;
    logic       cfg_parity_en;
    logic       cfg_parity_type;
    logic       cfg_pending;
    logic       cfg_reject;
    logic [5:0] uart_prescale;
    logic       uart_parity_en;
    logic       uart_parity_type;
    logic       rx_data_valid;
    logic [7:0] rx_p_data;
    logic       rx_parity_error;
    logic       rx_stop_error;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [3:0] fifo_level;
    logic       overflow;
    logic       err_clear;
    logic [7:0] parity_err_cnt;
    logic [7:0] stop_err_cnt;

    int n_cmp = 0;
    int n_err = 0;

`ifdef UART_RX_CTRL_ERRCNT_EN
    localparam logic [7:0] E1 = 8'd1;
`else
    localparam logic [7:0] E1 = 8'd0;
`endif

    uart_rx_ctrl dut (
        .CLK              (CLK),
        .RST              (RST),
        .RX_IN            (RX_IN),
        .cfg_update       (cfg_update),
        .cfg_prescale     (cfg_prescale),
        .cfg_parity_en    (cfg_parity_en),
        .cfg_parity_type  (cfg_parity_type),
        .cfg_pending      (cfg_pending),
        .cfg_reject       (cfg_reject),
        .uart_prescale    (uart_prescale),
        .uart_parity_en   (uart_parity_en),
        .uart_parity_type (uart_parity_type),
        .rx_data_valid    (rx_data_valid),
        .rx_p_data        (rx_p_data),
        .rx_parity_error  (rx_parity_error),
        .rx_stop_error    (rx_stop_error),
        .rd_data          (rd_data),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .fifo_level       (fifo_level),
        .overflow         (overflow),
        .err_clear        (err_clear),
        .parity_err_cnt   (parity_err_cnt),
        .stop_err_cnt     (stop_err_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // kind: 0 good byte, 1 parity error, 2 stop error
    task automatic send_frame(input logic [7:0] b, input int kind, input logic pop_at_end);
        RX_IN = 1'b0;
        repeat (20) tick();
        rx_p_data = b;
        case (kind)
            0:       rx_data_valid   = 1'b1;
            1:       rx_parity_error = 1'b1;
            default: rx_stop_error   = 1'b1;
        endcase
        rd_ready = pop_at_end;
        tick();
        rx_data_valid   = 1'b0;
        rx_parity_error = 1'b0;
        rx_stop_error   = 1'b0;
        rd_ready        = 1'b0;
        RX_IN           = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        logic [7:0] exp_b;
        RST = 1'b1; RX_IN = 1'b1; cfg_update = 1'b0; cfg_prescale = 6'd8;
        cfg_parity_en = 1'b0; cfg_parity_type = 1'b0; rx_data_valid = 1'b0;
        rx_p_data = 8'h00; rx_parity_error = 1'b0; rx_stop_error = 1'b0;
        rd_ready = 1'b0; err_clear = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        tick();

        // reset state
        check("rst_rd_valid", rd_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_presc", uart_prescale, 8);
        check("rst_pen", uart_parity_en, 0);
        check("rst_pending", cfg_pending, 0);
        check("rst_reject", cfg_reject, 0);
        check("rst_pcnt", parity_err_cnt, 0);
        check("rst_scnt", stop_err_cnt, 0);

        // 1: odd parity, prescale 8, one good frame
        cfg_prescale = 6'd8; cfg_parity_en = 1'b1; cfg_parity_type = 1'b1; cfg_update = 1'b1;
        tick();
        cfg_update = 1'b0;
        check("t1_pending_set", cfg_pending, 1);
        check("t1_pen_not_yet", uart_parity_en, 0);
        tick();
        check("t1_pending_clr", cfg_pending, 0);
        check("t1_pen", uart_parity_en, 1);
        check("t1_ptype", uart_parity_type, 1);
        send_frame(8'h07, 0, 1'b0);
        check("t1_rd_valid", rd_valid, 1);
        check("t1_rd_data", rd_data, 8'h07);
        check("t1_level", fifo_level, 1);
        check("t1_pcnt", parity_err_cnt, 0);
        check("t1_scnt", stop_err_cnt, 0);

        // 2: prescale change requested mid-frame waits for IDLE
        RX_IN = 1'b0;
        repeat (10) tick();
        cfg_prescale = 6'd16; cfg_update = 1'b1;
        tick();
        cfg_update = 1'b0;
        repeat (3) tick();
        check("t2_pending", cfg_pending, 1);
        check("t2_presc_frame", uart_prescale, 8);
        rx_p_data = 8'h5A; rx_data_valid = 1'b1;
        tick();
        rx_data_valid = 1'b0; RX_IN = 1'b1;
        check("t2_presc_waithi", uart_prescale, 8);
        repeat (5) tick();
        check("t2_presc_applied", uart_prescale, 16);
        check("t2_pending_clr", cfg_pending, 0);
        check("t2_level", fifo_level, 2);
        rd_ready = 1'b1;
        tick();
        check("t2_pop1_data", rd_data, 8'h5A);
        check("t2_pop1_level", fifo_level, 1);
        tick();
        rd_ready = 1'b0;
        check("t2_drained", fifo_level, 0);
        check("t2_rd_valid", rd_valid, 0);

        // 3: error frames discarded and counted, then cleared
        send_frame(8'h33, 2, 1'b0);
        check("t3_stop_level", fifo_level, 0);
        check("t3_scnt", stop_err_cnt, E1);
        check("t3_pcnt0", parity_err_cnt, 0);
        send_frame(8'h44, 1, 1'b0);
        check("t3_par_level", fifo_level, 0);
        check("t3_pcnt", parity_err_cnt, E1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("t3_clr_pcnt", parity_err_cnt, 0);
        check("t3_clr_scnt", stop_err_cnt, 0);

        // 4: fill, overflow, push+pop on full, drain
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 0, 1'b0);
        check("t4_full_level", fifo_level, 8);
        check("t4_no_ovf_yet", overflow, 0);
        send_frame(8'h18, 0, 1'b0);
        check("t4_ovf_level", fifo_level, 8);
        check("t4_ovf", overflow, 1);
        check("t4_head", rd_data, 8'h10);
        send_frame(8'h19, 0, 1'b1);
        check("t4_pushpop_level", fifo_level, 8);
        check("t4_pushpop_head", rd_data, 8'h11);
        check("t4_ovf_sticky", overflow, 1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("t4_pop_level", fifo_level, 7);
        check("t4_pop_head", rd_data, 8'h12);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("t4_ovf_clr", overflow, 0);
        for (int i = 0; i < 7; i++) begin
            exp_b = (i < 6) ? 8'h12 + 8'(i) : 8'h19;
            check("t4_drain_data", rd_data, exp_b);
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        check("t4_drain_level", fifo_level, 0);
        check("t4_drain_valid", rd_valid, 0);

        // 5: illegal prescale rejected
        cfg_prescale = 6'd12; cfg_update = 1'b1;
        tick();
        cfg_update = 1'b0;
        check("t5_reject", cfg_reject, 1);
        check("t5_pending", cfg_pending, 0);
        tick();
        check("t5_reject_pulse", cfg_reject, 0);
        check("t5_presc", uart_prescale, 16);

        // 6: false start times out after 16*12 cycles with no flags
        RX_IN = 1'b0;
        repeat (5) tick();
        cfg_prescale = 6'd8; cfg_update = 1'b1;
        tick();
        cfg_update = 1'b0;
        repeat (10) tick();
        RX_IN = 1'b1;
        repeat (130) tick();
        check("t6_still_frame_presc", uart_prescale, 16);
        check("t6_still_pending", cfg_pending, 1);
        repeat (74) tick();
        check("t6_timeout_presc", uart_prescale, 8);
        check("t6_timeout_pending", cfg_pending, 0);
        check("t6_level", fifo_level, 0);
        rx_p_data = 8'hEE; rx_data_valid = 1'b1;
        tick();
        rx_data_valid = 1'b0;
        repeat (2) tick();
        check("t6_idle_valid_ignored", fifo_level, 0);
        check("t6_rd_valid", rd_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
